// File: rtl/regfile_wb_queue.sv
// Write-back collection queue in front of the integer register-file RAM: gathers up to
// three results per cycle, drains up to two in order. Optional same-cycle bypass: REGFILE_WB_BYPASS_EN.
module regfile_wb_queue #(
  parameter int DATAWIDTH = 64,
  parameter int INDEXSIZE = 32,
  parameter int LOGINDEX  = 5,
  parameter int DEPTH     = 8,
  parameter int LOGDEPTH  = 3,
  parameter int ZERO_REG  = 31
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ld_valid_in,
  input  logic [LOGINDEX-1:0]  ld_index_in,
  input  logic [DATAWIDTH-1:0] ld_data_in,
  input  logic                 e0_valid_in,
  input  logic [LOGINDEX-1:0]  e0_index_in,
  input  logic [DATAWIDTH-1:0] e0_data_in,
  input  logic                 e1_valid_in,
  input  logic [LOGINDEX-1:0]  e1_index_in,
  input  logic [DATAWIDTH-1:0] e1_data_in,
  output logic                 stall_out,
  output logic                 we1_out,
  output logic [LOGINDEX-1:0]  index1_out,
  output logic [DATAWIDTH-1:0] data1_out,
  output logic                 we2_out,
  output logic [LOGINDEX-1:0]  index2_out,
  output logic [DATAWIDTH-1:0] data2_out,
  output logic [INDEXSIZE-1:0] pending_mask_out,
  output logic [LOGDEPTH:0]    count_out
);

  localparam logic [LOGINDEX-1:0] ZIDX        = LOGINDEX'(ZERO_REG);
  localparam logic [LOGDEPTH:0]   STALL_LIMIT = (LOGDEPTH+1)'(DEPTH-3);

  logic [LOGINDEX-1:0]  ent_idx  [DEPTH];
  logic [DATAWIDTH-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]     ent_valid;
  logic [LOGDEPTH-1:0]  head, tail, head_p1;
  logic [LOGDEPTH:0]    count;

  logic [2:0]           src_acc;
  logic [LOGINDEX-1:0]  src_idx  [3];
  logic [DATAWIDTH-1:0] src_data [3];
  logic [LOGINDEX-1:0]  lst_idx  [3];
  logic [DATAWIDTH-1:0] lst_data [3];
  logic [1:0]           nacc, byp_n, enq_n, drain_n;
  logic [2:0]           enq_en;
  logic [LOGDEPTH-1:0]  enq_slot [3];
  logic                 q_we1, q_we2, byp_on, b1, b2;

  // Handshake: producers present valid results; while stall_out is high every
  // valid is ignored and producers must hold. stall_out depends only on the
  // registered count, so a low stall_out always leaves room for three enqueues.
  assign stall_out = (count > STALL_LIMIT);
  assign count_out = count;
  assign head_p1   = head + LOGDEPTH'(1);

  always_comb begin
    src_idx[0]  = ld_index_in;
    src_idx[1]  = e0_index_in;
    src_idx[2]  = e1_index_in;
    src_data[0] = ld_data_in;
    src_data[1] = e0_data_in;
    src_data[2] = e1_data_in;
    src_acc[0]  = ld_valid_in && (ld_index_in != ZIDX) && !stall_out;
    src_acc[1]  = e0_valid_in && (e0_index_in != ZIDX) && !stall_out;
    src_acc[2]  = e1_valid_in && (e1_index_in != ZIDX) && !stall_out;
  end

  // Compact accepted sources into program order ld, e0, e1.
  always_comb begin
    int n;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      lst_idx[k]  = '0;
      lst_data[k] = '0;
    end
    for (int i = 0; i < 3; i++) begin
      if (src_acc[i]) begin
        lst_idx[n]  = src_idx[i];
        lst_data[n] = src_data[i];
        n++;
      end
    end
    nacc = 2'(n);
  end

`ifdef REGFILE_WB_BYPASS_EN
  logic live;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) live <= 1'b0;
    else       live <= 1'b1;
  end
  assign byp_on = live && (count == '0);
`else
  assign byp_on = 1'b0;
`endif

  assign b1    = byp_on && (nacc >= 2'd1);
  assign b2    = byp_on && (nacc >= 2'd2) && (lst_idx[1] != lst_idx[0]);
  assign byp_n = {1'b0, b1} + {1'b0, b2};
  assign enq_n = nacc - byp_n;

  // A second queued entry to the same register waits a cycle to keep write order.
  assign q_we1   = (count != '0);
  assign q_we2   = (count >= (LOGDEPTH+1)'(2)) && (ent_idx[head_p1] != ent_idx[head]);
  assign drain_n = {1'b0, q_we1} + {1'b0, q_we2};

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      enq_en[k]   = (2'(k) >= byp_n) && (2'(k) < nacc);
      enq_slot[k] = tail + LOGDEPTH'(2'(k) - byp_n);
    end
  end

  always_comb begin
    we1_out    = q_we1 | b1;
    index1_out = '0;
    data1_out  = '0;
    we2_out    = q_we2 | b2;
    index2_out = '0;
    data2_out  = '0;
    if (q_we1) begin
      index1_out = ent_idx[head];
      data1_out  = ent_data[head];
    end else if (b1) begin
      index1_out = lst_idx[0];
      data1_out  = lst_data[0];
    end
    if (q_we2) begin
      index2_out = ent_idx[head_p1];
      data2_out  = ent_data[head_p1];
    end else if (b2) begin
      index2_out = lst_idx[1];
      data2_out  = lst_data[1];
    end
  end

  always_comb begin
    pending_mask_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) pending_mask_out[ent_idx[i]] = 1'b1;
    end
    if (b1) pending_mask_out[lst_idx[0]] = 1'b1;
    if (b2) pending_mask_out[lst_idx[1]] = 1'b1;
    pending_mask_out[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      // Drained and enqueued slots never overlap: a non-stalled queue has three free slots.
      if (q_we1) ent_valid[head]    <= 1'b0;
      if (q_we2) ent_valid[head_p1] <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (enq_en[k]) ent_valid[enq_slot[k]] <= 1'b1;
      end
      head  <= head + LOGDEPTH'(drain_n);
      tail  <= tail + LOGDEPTH'(enq_n);
      count <= count + (LOGDEPTH+1)'(enq_n) - (LOGDEPTH+1)'(drain_n);
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (enq_en[k]) begin
        ent_idx[enq_slot[k]]  <= lst_idx[k];
        ent_data[enq_slot[k]] <= lst_data[k];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue (default build, queued path only).
module tb_regfile_wb_queue;
  localparam int DW = 64;
  localparam int LI = 5;
  localparam int W  = LI + DW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ld_valid_in = 1'b0, e0_valid_in = 1'b0, e1_valid_in = 1'b0;
  logic [LI-1:0] ld_index_in = '0, e0_index_in = '0, e1_index_in = '0;
  logic [DW-1:0] ld_data_in = '0, e0_data_in = '0, e1_data_in = '0;
  logic          stall_out, we1_out, we2_out;
  logic [LI-1:0] index1_out, index2_out;
  logic [DW-1:0] data1_out, data2_out;
  logic [31:0]   pending_mask_out;
  logic [3:0]    count_out;

  logic [DW-1:0] ram [32];
  logic [W-1:0]  exp_q[$];
  int checks = 0;
  int errors = 0;

  regfile_wb_queue dut (
    .clock(clock), .reset(reset),
    .ld_valid_in(ld_valid_in), .ld_index_in(ld_index_in), .ld_data_in(ld_data_in),
    .e0_valid_in(e0_valid_in), .e0_index_in(e0_index_in), .e0_data_in(e0_data_in),
    .e1_valid_in(e1_valid_in), .e1_index_in(e1_index_in), .e1_data_in(e1_data_in),
    .stall_out(stall_out),
    .we1_out(we1_out), .index1_out(index1_out), .data1_out(data1_out),
    .we2_out(we2_out), .index2_out(index2_out), .data2_out(data2_out),
    .pending_mask_out(pending_mask_out), .count_out(count_out)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // register-file RAM the queue feeds
  always @(posedge clock) begin
    if (we1_out) ram[index1_out] <= data1_out;
    if (we2_out) ram[index2_out] <= data2_out;
  end

  // drivers
  task automatic set_idle();
    ld_valid_in = 1'b0; e0_valid_in = 1'b0; e1_valid_in = 1'b0;
  endtask

  task automatic drive3(input logic [2:0] v, input logic [LI-1:0] i0, i1, i2,
                        input logic [DW-1:0] d0, d1, d2);
    ld_valid_in = v[0]; ld_index_in = i0; ld_data_in = d0;
    e0_valid_in = v[1]; e0_index_in = i1; e0_data_in = d1;
    e1_valid_in = v[2]; e1_index_in = i2; e1_data_in = d2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    repeat (2) @(negedge clock);
    checks++; if ({we1_out, we2_out, stall_out} !== 3'b000) begin errors++; $display("FAIL reset_we_stall: got %b want 000", {we1_out, we2_out, stall_out}); end
    checks++; if (count_out !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_out); end
    checks++; if (pending_mask_out !== 32'd0) begin errors++; $display("FAIL reset_mask: got %h want 0", pending_mask_out); end
    reset = 1'b0;
    #1;
    checks++; if ({we1_out, we2_out, stall_out, count_out, pending_mask_out} !== '0) begin errors++; $display("FAIL post_release_zero: outputs not all zero"); end
  endtask

  task automatic test_single_ld();
    drive3(3'b001, 5'd3, 5'd0, 5'd0, 64'hAA, 64'h0, 64'h0);
    @(negedge clock);
    set_idle();
    checks++; if ({we1_out, index1_out, data1_out} !== {1'b1, 5'd3, 64'hAA}) begin errors++; $display("FAIL ld_port1: got we=%b idx=%0d data=%h want 1/3/aa", we1_out, index1_out, data1_out); end
    checks++; if (we2_out !== 1'b0) begin errors++; $display("FAIL ld_port2: got we2=%b want 0", we2_out); end
    checks++; if (pending_mask_out !== 32'h8) begin errors++; $display("FAIL ld_mask: got %h want 8", pending_mask_out); end
    @(negedge clock);
    checks++; if ({pending_mask_out, count_out, we1_out} !== '0) begin errors++; $display("FAIL ld_drained: mask=%h count=%0d we1=%b want 0/0/0", pending_mask_out, count_out, we1_out); end
    checks++; if (ram[3] !== 64'hAA) begin errors++; $display("FAIL ld_ram: got %h want aa", ram[3]); end
  endtask

  task automatic test_three();
    drive3(3'b111, 5'd1, 5'd2, 5'd3, 64'h11, 64'h22, 64'h33);
    @(negedge clock);
    set_idle();
    checks++; if (count_out !== 4'd3) begin errors++; $display("FAIL three_count: got %0d want 3", count_out); end
    checks++; if (pending_mask_out !== 32'hE) begin errors++; $display("FAIL three_mask: got %h want e", pending_mask_out); end
    checks++; if ({we1_out, index1_out, data1_out, we2_out, index2_out, data2_out} !== {1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22}) begin errors++; $display("FAIL three_first: got %0d/%h %0d/%h want 1/11 2/22", index1_out, data1_out, index2_out, data2_out); end
    @(negedge clock);
    checks++; if ({we1_out, index1_out, data1_out, we2_out, count_out} !== {1'b1, 5'd3, 64'h33, 1'b0, 4'd1}) begin errors++; $display("FAIL three_second: got we1=%b %0d/%h we2=%b count=%0d want 1 3/33 0 1", we1_out, index1_out, data1_out, we2_out, count_out); end
    @(negedge clock);
    checks++; if (count_out !== 4'd0) begin errors++; $display("FAIL three_empty: got %0d want 0", count_out); end
  endtask

  task automatic test_same_index();
    drive3(3'b110, 5'd0, 5'd5, 5'd5, 64'h0, 64'h10, 64'h20);
    @(negedge clock);
    set_idle();
    checks++; if ({we1_out, index1_out, data1_out, we2_out} !== {1'b1, 5'd5, 64'h10, 1'b0}) begin errors++; $display("FAIL same_first: got we1=%b %0d/%h we2=%b want 1 5/10 0", we1_out, index1_out, data1_out, we2_out); end
    checks++; if (pending_mask_out !== 32'h20) begin errors++; $display("FAIL same_mask: got %h want 20", pending_mask_out); end
    @(negedge clock);
    checks++; if ({we1_out, index1_out, data1_out, we2_out, count_out} !== {1'b1, 5'd5, 64'h20, 1'b0, 4'd1}) begin errors++; $display("FAIL same_second: got we1=%b %0d/%h count=%0d want 1 5/20 1", we1_out, index1_out, data1_out, count_out); end
    @(negedge clock);
    checks++; if (ram[5] !== 64'h20) begin errors++; $display("FAIL same_ram: got %h want 20", ram[5]); end
  endtask

  task automatic test_zero_reg();
    drive3(3'b001, 5'd31, 5'd0, 5'd0, 64'hFF, 64'h0, 64'h0);
    @(negedge clock);
    set_idle();
    checks++; if ({count_out, we1_out, we2_out, pending_mask_out} !== '0) begin errors++; $display("FAIL zero_only: count=%0d we1=%b mask=%h want all 0", count_out, we1_out, pending_mask_out); end
    drive3(3'b011, 5'd31, 5'd7, 5'd0, 64'hFF, 64'h77, 64'h0);
    @(negedge clock);
    set_idle();
    checks++; if ({count_out, index1_out, data1_out, we2_out, pending_mask_out} !== {4'd1, 5'd7, 64'h77, 1'b0, 32'h80}) begin errors++; $display("FAIL zero_mixed: count=%0d idx=%0d data=%h mask=%h want 1 7 77 80", count_out, index1_out, data1_out, pending_mask_out); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int seq = 0;
    int cyc = 0;
    bit saw_stall = 0;
    logic [W-1:0] got;
    while ((cyc < 40 || exp_q.size() != 0) && cyc < 120) begin
      checks++; if (count_out !== 4'(exp_q.size())) begin errors++; $display("FAIL b2b_count c%0d: got %0d want %0d", cyc, count_out, exp_q.size()); end
      checks++; if (stall_out !== (exp_q.size() > 5)) begin errors++; $display("FAIL b2b_stall c%0d: got %b want %b", cyc, stall_out, exp_q.size() > 5); end
      if (stall_out) saw_stall = 1;
      if (we1_out) begin
        got = {index1_out, data1_out};
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_port1 c%0d: got %h want none", cyc, got); end
        else begin
          if (got !== exp_q[0]) begin errors++; $display("FAIL b2b_port1 c%0d: got %h want %h", cyc, got, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      if (we2_out) begin
        got = {index2_out, data2_out};
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_port2 c%0d: got %h want none", cyc, got); end
        else begin
          if (got !== exp_q[0]) begin errors++; $display("FAIL b2b_port2 c%0d: got %h want %h", cyc, got, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      if (cyc < 40) begin
        if (!stall_out) begin
          drive3(3'b111, 5'((seq) % 31), 5'((seq + 1) % 31), 5'((seq + 2) % 31),
                 64'hD000 + 64'(seq), 64'hD000 + 64'(seq + 1), 64'hD000 + 64'(seq + 2));
          for (int k = 0; k < 3; k++) exp_q.push_back({5'((seq + k) % 31), 64'hD000 + 64'(seq + k)});
          seq += 3;
        end
      end else begin
        set_idle();
      end
      @(negedge clock);
      cyc++;
    end
    set_idle();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: %0d entries never issued", exp_q.size()); end
    checks++; if (saw_stall !== 1'b1) begin errors++; $display("FAIL b2b_saw_stall: got %b want 1", saw_stall); end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      drive3(3'b111, 5'(3 * c + 8), 5'(3 * c + 9), 5'(3 * c + 10),
             64'hE0 + 64'(c), 64'hE4 + 64'(c), 64'hE8 + 64'(c));
      @(negedge clock);
    end
    set_idle();
    checks++; if (count_out !== 4'd5) begin errors++; $display("FAIL mid_count: got %0d want 5", count_out); end
    reset = 1'b1;
    #1;
    checks++; if ({we1_out, we2_out, stall_out, count_out, pending_mask_out} !== '0) begin errors++; $display("FAIL mid_async: we1=%b we2=%b stall=%b count=%0d mask=%h want all 0", we1_out, we2_out, stall_out, count_out, pending_mask_out); end
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++; if ({we1_out, we2_out, count_out} !== '0) begin errors++; $display("FAIL mid_after c%0d: we1=%b we2=%b count=%0d want 0", c, we1_out, we2_out, count_out); end
    end
  endtask

  initial begin
    test_reset();
    test_single_ld();
    test_three();
    test_same_index();
    test_zero_reg();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-back collection stage directly upstream of the integer register-file dual-port RAM.
- Accepts results from up to three producers per cycle: load pipe, E0 pipe and E1 pipe.
- Buffers them in an in-order FIFO and drains up to two entries per cycle onto the RAM's two write ports.
- Discards writes to the hardwired zero register and publishes a pending-write mask so readers of the RAM's combinational read ports can detect stale data.

Parameters:
- DATAWIDTH, 64, result width; matches the RAM.
- INDEXSIZE, 32, number of architectural registers.
- LOGINDEX, 5, register index width.
- DEPTH, 8, FIFO entries; power of two, minimum 4.
- LOGDEPTH, 3, log2(DEPTH).
- ZERO_REG, 31, index whose writes are dropped.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ld_valid_in  in  1  load result valid.
- ld_index_in  in  LOGINDEX  load destination.
- ld_data_in  in  DATAWIDTH  load data.
- e0_valid_in / e0_index_in / e0_data_in  in  1 / LOGINDEX / DATAWIDTH  E0 result.
- e1_valid_in / e1_index_in / e1_data_in  in  1 / LOGINDEX / DATAWIDTH  E1 result.
- stall_out  out  1  producers must hold; valids are ignored while high.
- we1_out  out  1  RAM port-1 write enable.
- index1_out  out  LOGINDEX  RAM port-1 index.
- data1_out  out  DATAWIDTH  RAM port-1 data.
- we2_out  out  1  RAM port-2 write enable.
- index2_out  out  LOGINDEX  RAM port-2 index.
- data2_out  out  DATAWIDTH  RAM port-2 data.
- pending_mask_out  out  INDEXSIZE  bit i = 1 iff the queue holds a write to register i.
- count_out  out  LOGDEPTH+1  current occupancy.

Behaviour:
- State:
  - entry array of {index, data}, with valid bits.
  - head and tail pointers, LOGDEPTH bits, wrap modulo DEPTH.
  - count register, LOGDEPTH+1 bits.
- Reset (asynchronous, active-high):
  - pointers, count and all entry valid bits cleared.
  - All outputs read 0 while reset is asserted and in the first cycle after release.
- stall_out = (count > DEPTH-3), combinational from the registered count only.
  - Guarantees room for 3 enqueues regardless of drain.
- Enqueue, while stall_out=0:
  - Each valid source with index != ZERO_REG is written at tail in fixed order ld, e0, e1.
  - tail advances by the number written (0..3).
  - Sources with index == ZERO_REG are consumed and never stored.
- Enqueue while stall_out=1: all input valids are ignored; nothing is enqueued. Producers hold.
- Drain (combinational from queue state):
  - Port 1 gets the head entry if count>=1.
  - Port 2 gets head+1 if count>=2 and its index differs from the head's index.
  - If both indices are equal, only port 1 issues; head+1 waits one cycle. This preserves write order.
  - head advances by the number issued at the clock edge.
  - Any port not issuing drives we=0, index=0, data=0.
- Latency: a result presented at edge N is written into the RAM at edge N+1, first visible on RAM reads after edge N+1.
- count_next = count + enq_n - drain_n.
  - Simultaneous enqueue and drain are legal at any occupancy.
  - count never exceeds DEPTH.
- pending_mask_out: OR over valid entries of the one-hot of the entry index.
  - Combinational, includes entries being drained this cycle.
  - Bit ZERO_REG is always 0.
- Reset mid-operation: all queued writes are lost; no RAM write is issued after reset asserts.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined, when count==0:
  - Valid non-zero-register inputs drive the RAM ports combinationally in the same cycle, in order ld, e0, e1.
  - At most 2 issue, subject to the same equal-index rule.
  - Only the leftover inputs enqueue.
  - Latency becomes 0 cycles (written at edge N).
  - pending_mask_out also includes bypassed entries.
- Undefined: the bypass logic is absent and all writes take the queued path.

Test Plan:
- Reset, then ld only (index 3, data 0xAA) → the next cycle shows we1=1, index1=3, data1=0xAA, we2=0, pending_mask bit3=1; the following cycle pending_mask=0 and count=0.
- ld, e0, e1 together at indices 1, 2, 3 → queue count=3; next cycle ports 1/2 write indices 1 and 2; the cycle after, port 1 writes index 3.
- e0 and e1 both at index 5 (data 0x10, 0x20) in one cycle → the first drain cycle writes only 0x10 on port 1; the next cycle writes 0x20 on port 1; final RAM value is 0x20.
- ld at index 31 (ZERO_REG) → count stays 0, no we, pending_mask=0.
- Keep 3 inputs valid every cycle to distinct indices → stall_out rises once count reaches 6; no entry is lost or duplicated; issue order equals enqueue order.
- Assert reset while count=5 → we1=we2=0, count=0 and stall_out=0 immediately (asynchronous).
